mem_wb_stage_buf: RTL and testbench
===================================

// Module: mem_wb_stage_buf
// PURPOSE
//  Parametrised MEM->WB pipeline stage register with valid/ready handshake, optional skid entry,
//  synchronous flush and a saturating stall-cycle counter. Sits between data-memory access and
//  register write-back. Captures {WB ctrl, mem address, read data} and holds it under back-pressure.
//  Bubbles never carry live write-back control.
// PARAMETERS
//  DATA_W    32  read-data width
//  ADDR_W    13  data-memory address width
//  CTRL_W    2   WB control width; bit1 = RegWrite, bit0 = MemToReg
//  SKID      1   1: 2-entry (main + skid), in_ready registered; 0: single entry, in_ready combinational
//  STALL_W   16  stall counter width
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        reset, asynchronous, active-high
//  flush      in   1        synchronous flush (kill all held entries)
//  in_valid   in   1        upstream payload valid
//  in_ready   out  1        stage can accept this cycle
//  in_ctrl    in   CTRL_W   WB control in
//  in_addr    in   ADDR_W   address in
//  in_data    in   DATA_W   read data in
//  out_valid  out  1        payload valid to WB
//  out_ready  in   1        WB consumes this cycle
//  out_ctrl   out  CTRL_W   WB control out; 0 whenever out_valid=0
//  out_addr   out  ADDR_W   address out
//  out_data   out  DATA_W   read data out
//  clr_stat   in   1        synchronous clear of stall_cnt
//  stall_cnt  out  STALL_W  cycles with out_valid=1 & out_ready=0
// BEHAVIOUR
//  Reset: out_valid=0, out_ctrl/out_addr/out_data=0, skid entry invalid and zeroed, stall_cnt=0,
//   in_ready=1 (SKID=1); in_ready=1 while reset released and empty (SKID=0).
//  acc = in_valid & in_ready; pop = out_valid & out_ready. Evaluated every rising clk edge.
//  Latency: accepted payload appears on out_* the next cycle when main entry empty or popping.
//  SKID=1: in_ready = ~skid_valid (register, no comb path from out_ready).
//   main empty or pop: main <= skid if skid_valid (skid_valid<=0, then acc fills skid if present),
//    else main <= input if acc, else out_valid<=0, out_ctrl<=0 (addr/data hold).
//   main held (valid & ~out_ready): acc writes skid, skid_valid<=1, in_ready drops next cycle.
//   Order strictly FIFO: skid entry always older than any new input.
//  SKID=0: in_ready = ~out_valid | out_ready; main loads on acc, clears valid on pop without acc.
//  Simultaneous acc and pop with main valid, skid empty: main replaced by input, no bubble.
//  flush (priority over acc/pop): out_valid<=0, out_ctrl<=0, skid_valid<=0, input this cycle
//   dropped; addr/data hold. in_ready=1 the following cycle.
//  stall_cnt: +1 each cycle out_valid & ~out_ready, saturates at all-ones; clr_stat wins over
//   increment (result 0). flush does not clear it.
//  Async rst mid-transfer: all entries dropped immediately, outputs to reset values.
// TESTING
//  1 Reset: rst=1 mid-stream -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0.
//  2 Stream: out_ready=1, push ctrl=2'b11 addr=13'h0004 data=32'hDEADBEEF then 13'h0008/32'h12345678
//    back-to-back -> appear on consecutive cycles, 1-cycle latency, no bubble.
//  3 Back-pressure (SKID=1): out_ready=0, push A,B,C -> A held on out, B in skid, in_ready=0, C
//    not accepted; release out_ready -> A,B,C in order; stall_cnt counts held cycles exactly.
//  4 Flush: main+skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0,
//    in_ready=1; dropped payload never appears.
//  5 Saturation: STALL_W=4, hold out_valid with out_ready=0 for 20 cycles -> stall_cnt=4'hF;
//    clr_stat=1 same cycle as stall -> 0.
//  6 SKID=0: out_ready=0 with out_valid=1 -> in_ready=0 same cycle; out_ready=1 with in_valid=1
//    -> simultaneous pop and accept, new payload next cycle.

Source files
------------

// File: rtl/mem_wb_stage_buf.sv
// mem_wb_stage_buf
//   MEM->WB pipeline stage register. It captures {write-back control,
//   memory address, read data} under a valid/ready handshake and holds
//   it while write-back applies back-pressure. SKID=1 adds a second
//   (skid) entry so that in_ready comes straight from a flop. SKID=0 keeps
//   a single entry, and in_ready then depends combinationally on
//   out_ready. A synchronous flush kills every held entry. A saturating
//   counter records the cycles that were stalled.
//
// Parameters
//   DATA_W   read-data width
//   ADDR_W   data-memory address width
//   CTRL_W   write-back control width (bit1 RegWrite, bit0 MemToReg)
//   SKID     1: main + skid entry, registered in_ready; 0: single entry
//   STALL_W  stall counter width
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   flush                 synchronous kill of all held entries
//   in_valid/in_ready     upstream handshake
//   in_ctrl/addr/data     incoming payload
//   out_valid/out_ready   downstream handshake
//   out_ctrl/addr/data    outgoing payload; out_ctrl is 0 while out_valid=0
//   clr_stat              synchronous clear of stall_cnt
//   stall_cnt             count of cycles with out_valid=1 and out_ready=0
module mem_wb_stage_buf #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned CTRL_W  = 2,
    parameter int unsigned SKID    = 1,
    parameter int unsigned STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [ADDR_W-1:0]  out_addr,
    output logic [DATA_W-1:0]  out_data,
    input  logic               clr_stat,
    output logic [STALL_W-1:0] stall_cnt
);

    logic               r_out_valid;
    logic [CTRL_W-1:0]  r_out_ctrl;
    logic [ADDR_W-1:0]  r_out_addr;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_skid_valid;
    logic [CTRL_W-1:0]  r_skid_ctrl;
    logic [ADDR_W-1:0]  r_skid_addr;
    logic [DATA_W-1:0]  r_skid_data;
    logic [STALL_W-1:0] r_stall_cnt;

    logic w_in_ready;
    logic w_acc;
    logic w_pop;
    logic w_main_free;

    // SKID=1: ready comes only from the skid flop. The skid entry fills
    // only while main is held, so "skid empty" is exactly "room for one more".
    always_comb begin
        if (SKID != 0) w_in_ready = ~r_skid_valid;
        else           w_in_ready = ~r_out_valid | out_ready;
    end

    assign w_acc       = in_valid & w_in_ready;
    assign w_pop       = r_out_valid & out_ready;
    assign w_main_free = ~r_out_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_ctrl   <= '0;
            r_out_addr   <= '0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_addr  <= '0;
            r_skid_data  <= '0;
        end else if (flush) begin
            // addr/data keep their values; only the control fields are killed
            r_out_valid  <= 1'b0;
            r_out_ctrl   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
        end else if (SKID != 0) begin
            if (w_main_free) begin
                if (r_skid_valid) begin
                    // The skid entry is older than any input, so it moves up
                    // first. in_ready was low, so no new input arrives here.
                    r_out_valid  <= 1'b1;
                    r_out_ctrl   <= r_skid_ctrl;
                    r_out_addr   <= r_skid_addr;
                    r_out_data   <= r_skid_data;
                    r_skid_valid <= 1'b0;
                    r_skid_ctrl  <= '0;
                end else if (w_acc) begin
                    r_out_valid <= 1'b1;
                    r_out_ctrl  <= in_ctrl;
                    r_out_addr  <= in_addr;
                    r_out_data  <= in_data;
                end else begin
                    r_out_valid <= 1'b0;
                    r_out_ctrl  <= '0;
                end
            end else if (w_acc) begin
                r_skid_valid <= 1'b1;
                r_skid_ctrl  <= in_ctrl;
                r_skid_addr  <= in_addr;
                r_skid_data  <= in_data;
            end
        end else begin
            if (w_acc) begin
                r_out_valid <= 1'b1;
                r_out_ctrl  <= in_ctrl;
                r_out_addr  <= in_addr;
                r_out_data  <= in_data;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
                r_out_ctrl  <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (clr_stat) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_ctrl  = r_out_ctrl;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mem_wb_stage_buf.sv
// tb_mem_wb_stage_buf
//   Two instances share one stimulus stream: dut0 (SKID=1, 16-bit counter)
//   and dut1 (SKID=0, 4-bit counter). Each instance is compared every
//   cycle against a queue-based model of a FIFO that holds 2 or 1 entries.
module tb_mem_wb_stage_buf;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, clr_stat;
    logic [1:0]  in_ctrl;
    logic [12:0] in_addr;
    logic [31:0] in_data;

    logic        in_ready0, out_valid0, in_ready1, out_valid1;
    logic [1:0]  out_ctrl0, out_ctrl1;
    logic [12:0] out_addr0, out_addr1;
    logic [31:0] out_data0, out_data1;
    logic [15:0] stall0;
    logic [3:0]  stall1;

    always #5 clk = ~clk;

    mem_wb_stage_buf #(.DATA_W(32), .ADDR_W(13), .CTRL_W(2), .SKID(1), .STALL_W(16)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_addr(in_addr), .in_data(in_data), .out_valid(out_valid0),
        .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_addr(out_addr0), .out_data(out_data0),
        .clr_stat(clr_stat), .stall_cnt(stall0));

    mem_wb_stage_buf #(.DATA_W(32), .ADDR_W(13), .CTRL_W(2), .SKID(0), .STALL_W(4)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_ctrl(in_ctrl), .in_addr(in_addr), .in_data(in_data), .out_valid(out_valid1),
        .out_ready(out_ready), .out_ctrl(out_ctrl1), .out_addr(out_addr1), .out_data(out_data1),
        .clr_stat(clr_stat), .stall_cnt(stall1));

    logic [64:0] obs0;
    logic [52:0] obs1;
    assign obs0 = {in_ready0, out_valid0, out_ctrl0, out_addr0, out_data0, stall0};
    assign obs1 = {in_ready1, out_valid1, out_ctrl1, out_addr1, out_data1, stall1};

    // Model: each entry is {ctrl, addr, data}; q*[0] is the entry on out_*.
    logic [46:0] q0[$];
    logic [46:0] q1[$];
    logic [44:0] last0, last1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;
    int errors = 0;
    int checks = 0;

    function automatic logic [64:0] exp0_f();
        logic [46:0] h;
        h = (q0.size() > 0) ? q0[0] : {2'b00, last0};
        return {q0.size() < 2, q0.size() > 0, h, cnt0};
    endfunction

    function automatic logic [52:0] exp1_f();
        logic [46:0] h;
        h = (q1.size() > 0) ? q1[0] : {2'b00, last1};
        return {(q1.size() == 0) || out_ready, q1.size() > 0, h, cnt1};
    endfunction

    // Advance one rising edge and apply the same edge to the model.
    task automatic tick();
        logic acc0, pop0, acc1, pop1;
        acc0 = in_valid && (q0.size() < 2);
        pop0 = (q0.size() > 0) && out_ready;
        acc1 = in_valid && ((q1.size() == 0) || out_ready);
        pop1 = (q1.size() > 0) && out_ready;
        @(posedge clk);
        if (clr_stat) begin
            cnt0 = '0; cnt1 = '0;
        end else begin
            if (q0.size() > 0 && !out_ready && cnt0 != 16'hFFFF) cnt0 = cnt0 + 1'b1;
            if (q1.size() > 0 && !out_ready && cnt1 != 4'hF)     cnt1 = cnt1 + 1'b1;
        end
        if (rst) begin
            q0.delete(); q1.delete();
            last0 = '0; last1 = '0; cnt0 = '0; cnt1 = '0;
        end else if (flush) begin
            q0.delete(); q1.delete();
        end else begin
            if (pop0) void'(q0.pop_front());
            if (acc0) q0.push_back({in_ctrl, in_addr, in_data});
            if (pop1) void'(q1.pop_front());
            if (acc1) q1.push_back({in_ctrl, in_addr, in_data});
        end
        if (q0.size() > 0) last0 = q0[0][44:0];
        if (q1.size() > 0) last1 = q1[0][44:0];
        #1;
    endtask

    task automatic test_reset();
        // Put some traffic in flight, then assert reset between clock edges.
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 2'b11; in_addr = 13'h0111; in_data = 32'hA5A5A5A5;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({obs0, obs1} !== {1'b1, 1'b0, 2'b0, 13'h0, 32'h0, 16'h0, 1'b1, 1'b0, 2'b0, 13'h0, 32'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset_async got=%h/%h required in_ready=1 others 0", obs0, obs1);
        end
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({obs0, obs1} !== {exp0_f(), exp1_f()}) begin
            errors++;
            $display("FAIL reset_release got=%h/%h required=%h/%h", obs0, obs1, exp0_f(), exp1_f());
        end
        tick();
    endtask

    task automatic test_stream();
        logic [46:0] p [2];
        p[0] = {2'b11, 13'h0004, 32'hDEADBEEF};
        p[1] = {2'b11, 13'h0008, 32'h12345678};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = (i < 2);
            {in_ctrl, in_addr, in_data} = p[(i < 2) ? i : 1];
            @(negedge clk);
            checks++;
            if ({obs0, obs1} !== {exp0_f(), exp1_f()}) begin
                errors++;
                $display("FAIL stream_cyc%0d got=%h/%h required=%h/%h", i, obs0, obs1, exp0_f(), exp1_f());
            end
            if (i == 1 || i == 2) begin
                checks++;
                if ({out_valid0, out_ctrl0, out_addr0, out_data0} !== {1'b1, p[i-1]}) begin
                    errors++;
                    $display("FAIL stream_latency%0d got=%h required=%h", i, {out_valid0, out_ctrl0, out_addr0, out_data0}, {1'b1, p[i-1]});
                end
            end
            tick();
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] d [3];
        logic [31:0] got[$];
        int idx;
        d[0] = 32'hAAAA0001; d[1] = 32'hBBBB0002; d[2] = 32'hCCCC0003;
        clr_stat = 1'b1; in_valid = 1'b0; tick(); clr_stat = 1'b0;
        out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc == 6) out_ready = 1'b1;
            in_valid = (idx < 3);
            in_ctrl = 2'b10; in_addr = 13'h0100 + 13'(idx); in_data = d[(idx < 3) ? idx : 2];
            @(negedge clk);
            checks++;
            if ({obs0, obs1} !== {exp0_f(), exp1_f()}) begin
                errors++;
                $display("FAIL backpressure_cyc%0d got=%h/%h required=%h/%h", cyc, obs0, obs1, exp0_f(), exp1_f());
            end
            if (cyc == 5) begin
                checks++;
                if ({in_ready0, out_valid0, out_data0, stall0} !== {1'b0, 1'b1, d[0], 16'd4}) begin
                    errors++;
                    $display("FAIL backpressure_hold got rdy=%b v=%b d=%h st=%0d required rdy=0 v=1 d=%h st=4",
                             in_ready0, out_valid0, out_data0, stall0, d[0]);
                end
            end
            if (out_valid0 && out_ready) got.push_back(out_data0);
            if (in_valid && q0.size() < 2) idx++;
            tick();
            if (idx == 3 && q0.size() == 0 && cyc > 6) break;
        end
        checks++;
        if (got.size() != 3 || got[0] !== d[0] || got[1] !== d[1] || got[2] !== d[2]) begin
            errors++;
            $display("FAIL backpressure_order got n=%0d first=%h required A,B,C=%h,%h,%h",
                     got.size(), (got.size() > 0) ? got[0] : 32'h0, d[0], d[1], d[2]);
        end
        checks++;
        if (stall0 !== 16'd5) begin
            errors++;
            $display("FAIL backpressure_stall got=%0d required=5", stall0);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 2'b11; in_addr = 13'h0200; in_data = 32'h11110000;
        for (int i = 0; i < 5 && q0.size() < 2; i++) begin
            tick();
            in_data = in_data + 1;
        end
        flush = 1'b1; in_data = 32'hD0D0D0D0; in_addr = 13'h1DDD;
        @(negedge clk);
        checks++;
        if ({obs0, obs1} !== {exp0_f(), exp1_f()}) begin
            errors++;
            $display("FAIL flush_pre got=%h/%h required=%h/%h", obs0, obs1, exp0_f(), exp1_f());
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid0, out_ctrl0, in_ready0, out_valid1, out_ctrl1} !== {1'b0, 2'b00, 1'b1, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL flush_kill got v=%b c=%b r=%b v1=%b c1=%b required 0,00,1,0,00",
                     out_valid0, out_ctrl0, in_ready0, out_valid1, out_ctrl1);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (({obs0, obs1} !== {exp0_f(), exp1_f()}) ||
                (out_valid0 && out_data0 === 32'hD0D0D0D0) || (out_valid1 && out_data1 === 32'hD0D0D0D0)) begin
                errors++;
                $display("FAIL flush_after%0d got=%h/%h required=%h/%h", i, obs0, obs1, exp0_f(), exp1_f());
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        clr_stat = 1'b1; tick(); clr_stat = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 2'b01; in_addr = 13'h0ABC; in_data = 32'h5A5A0000;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({obs0, obs1} !== {exp0_f(), exp1_f()}) begin
                errors++;
                $display("FAIL saturation_cyc%0d got=%h/%h required=%h/%h", i, obs0, obs1, exp0_f(), exp1_f());
            end
            tick();
        end
        checks++;
        if ({stall1, stall0} !== {4'hF, 16'd20}) begin
            errors++;
            $display("FAIL saturation_value got=%h/%0d required=f/20", stall1, stall0);
        end
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall1, stall0} !== {4'h0, 16'd0}) begin
            errors++;
            $display("FAIL saturation_clear got=%h/%0d required=0/0", stall1, stall0);
        end
    endtask

    task automatic test_no_skid();
        // dut1 still holds the payload from the saturation run with out_ready=0
        in_valid = 1'b1; in_ctrl = 2'b10; in_addr = 13'h0EEE; in_data = 32'hE0E0E0E0;
        #1;
        checks++;
        if ({out_valid1, in_ready1} !== 2'b10) begin
            errors++;
            $display("FAIL noskid_block got v=%b r=%b required v=1 r=0", out_valid1, in_ready1);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL noskid_comb_ready got=%b required=1", in_ready1);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid1, out_ctrl1, out_addr1, out_data1} !== {1'b1, 2'b10, 13'h0EEE, 32'hE0E0E0E0}) begin
            errors++;
            $display("FAIL noskid_swap got=%h required=%h", {out_valid1, out_ctrl1, out_addr1, out_data1},
                     {1'b1, 2'b10, 13'h0EEE, 32'hE0E0E0E0});
        end
        checks++;
        if ({obs0, obs1} !== {exp0_f(), exp1_f()}) begin
            errors++;
            $display("FAIL noskid_model got=%h/%h required=%h/%h", obs0, obs1, exp0_f(), exp1_f());
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 99) < 65);
            out_ready = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 99) < 4);
            clr_stat  = ($urandom_range(0, 99) < 3);
            in_ctrl = 2'($urandom); in_addr = 13'($urandom); in_data = $urandom;
            @(negedge clk);
            checks++;
            if ({obs0, obs1} !== {exp0_f(), exp1_f()}) begin
                errors++;
                $display("FAIL random_cyc%0d got=%h/%h required=%h/%h", i, obs0, obs1, exp0_f(), exp1_f());
            end
            tick();
        end
        flush = 1'b0; clr_stat = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_stat = 1'b0;
        in_ctrl = '0; in_addr = '0; in_data = '0;
        last0 = '0; last1 = '0; cnt0 = '0; cnt1 = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_saturation();
        test_no_skid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
